// File: rtl/hex_cal_ctrl.sv
// hex_cal_ctrl: command sequencer for the UART hex calculator.
// Parses <hexA><op><hexB><term> from received bytes, computes A+B or A-B
// (modulo 2^DW, carry/borrow on ovf) and transmits the result as ND upper-case
// hex digits followed by CR LF. Invalid input answers "?" CR LF.
// Optional feature macro: HEX_CAL_ECHO_EN -- when defined, every byte accepted
// while parsing is echoed through a one-entry buffer ahead of any response.
module hex_cal_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic          result_valid,
  output logic          err
);

  localparam int ND = DW / 4;
  // Index/count width: the longest response index is ND+1 <= 9.
  localparam int IW = 4;
  localparam logic [IW-1:0] ND_I      = IW'(ND);
  localparam logic [IW-1:0] LAST_SEND = IW'(ND + 1);
  localparam logic [IW-1:0] LAST_ERR  = IW'(2);
  localparam logic [7:0]    CH_CR     = 8'h0D;
  localparam logic [7:0]    CH_LF     = 8'h0A;
  localparam logic [7:0]    CH_QM     = 8'h3F;

  typedef enum logic [2:0] {S_A, S_B, S_CALC, S_SEND, S_ERR} state_t;

  state_t          state, state_n;
  logic            rx_valid_d;
  logic [DW-1:0]   a, b;
  logic [IW-1:0]   a_cnt, b_cnt;
  logic            op_sub;
  logic [IW-1:0]   send_idx, idx_n;
  logic            tx_gap;

  logic            accept;
  logic            is_digit, is_op, is_term;
  logic [3:0]      nib;
  logic [DW:0]     calc_ext;
  logic [DW-1:0]   res_sh;
  logic            can_issue, resp_ok;

  logic            issue;
  logic [7:0]      issue_byte;
  logic            shift_a, shift_b, latch_op, do_calc, clr;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // One accept per rx_valid high period; rx_valid_d resets high so a byte
  // already present during reset is never taken.
  assign accept = rx_valid & ~rx_valid_d;

  // Carry/borrow falls out of the extra MSB of a DW+1-bit operation.
  assign calc_ext = op_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});

  // Current response digit is always the top nibble of the shifted result.
  assign res_sh = result << {send_idx, 2'b00};

  // A new request needs an idle transmitter, seen outside the pulse cycle and
  // the cycle after it (the transmitter is still raising tx_busy then).
  assign can_issue = ~tx_busy & ~tx_start & ~tx_gap;

  assign err          = (state == S_ERR);
  assign result_valid = (state == S_CALC);

`ifdef HEX_CAL_ECHO_EN
  logic       echo_full;
  logic [7:0] echo_byte;
  logic       echo_sent;

  assign echo_sent = echo_full & can_issue;

  // One-entry echo buffer; a newer accept overwrites an unsent echo.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_full <= 1'b0;
      echo_byte <= 8'h00;
    end else if (accept && (state == S_A || state == S_B)) begin
      echo_full <= 1'b1;
      echo_byte <= rx_data;
    end else if (echo_sent) begin
      echo_full <= 1'b0;
    end
  end
`else
  logic       echo_full;
  logic [7:0] echo_byte;

  assign echo_full = 1'b0;
  assign echo_byte = 8'h00;
`endif

  // Responses wait behind any pending echo.
  assign resp_ok = can_issue & ~echo_full;

  // Classify the received byte into digit / operator / terminator.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    is_digit = 1'b0;
    nib      = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_digit = 1'b1;
      nib      = rx_data[3:0] + 4'd9;
    end
    is_op   = (rx_data == 8'h2B) || (rx_data == 8'h2D);
    is_term = (rx_data == 8'h3D) || (rx_data == 8'h0D);
  end

  // Next-state and control decode: parsing, calculation and tx scheduling.
  always_comb begin
    state_n    = state;
    idx_n      = send_idx;
    issue      = 1'b0;
    issue_byte = 8'h00;
    shift_a    = 1'b0;
    shift_b    = 1'b0;
    latch_op   = 1'b0;
    do_calc    = 1'b0;
    clr        = 1'b0;

    if (echo_full && can_issue) begin
      issue      = 1'b1;
      issue_byte = echo_byte;
    end

    unique case (state)
      S_A: begin
        if (accept) begin
          if (is_digit) begin
            shift_a = 1'b1;
          end else if (is_op && a_cnt != '0) begin
            latch_op = 1'b1;
            state_n  = S_B;
          end else begin
            state_n = S_ERR;
            idx_n   = '0;
          end
        end
      end
      S_B: begin
        if (accept) begin
          if (is_digit) begin
            shift_b = 1'b1;
          end else if (is_term && b_cnt != '0) begin
            state_n = S_CALC;
          end else begin
            state_n = S_ERR;
            idx_n   = '0;
          end
        end
      end
      S_CALC: begin
        // The first digit comes straight from the adder so it can go out
        // in the same cycle the result is registered.
        do_calc = 1'b1;
        state_n = S_SEND;
        idx_n   = '0;
        if (resp_ok) begin
          issue      = 1'b1;
          issue_byte = hex_char(calc_ext[DW-1 -: 4]);
          idx_n      = IW'(1);
        end
      end
      S_SEND: begin
        if (resp_ok) begin
          issue = 1'b1;
          if (send_idx == LAST_SEND) begin
            issue_byte = CH_LF;
            clr        = 1'b1;
            state_n    = S_A;
            idx_n      = '0;
          end else begin
            issue_byte = (send_idx == ND_I) ? CH_CR : hex_char(res_sh[DW-1 -: 4]);
            idx_n      = send_idx + IW'(1);
          end
        end
      end
      S_ERR: begin
        if (resp_ok) begin
          issue = 1'b1;
          if (send_idx == LAST_ERR) begin
            issue_byte = CH_LF;
            clr        = 1'b1;
            state_n    = S_A;
            idx_n      = '0;
          end else begin
            issue_byte = (send_idx == '0) ? CH_QM : CH_CR;
            idx_n      = send_idx + IW'(1);
          end
        end
      end
      default: state_n = S_A;
    endcase
  end

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_A;
    else     state <= state_n;
  end

  // Operand shift registers, digit counts, operator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_d <= 1'b1;
      a          <= '0;
      b          <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      op_sub     <= 1'b0;
      send_idx   <= '0;
      result     <= '0;
      ovf        <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      send_idx   <= idx_n;
      if (clr) begin
        a     <= '0;
        b     <= '0;
        a_cnt <= '0;
        b_cnt <= '0;
      end
      if (shift_a) begin
        a <= {a[DW-5:0], nib};
        if (a_cnt != ND_I) a_cnt <= a_cnt + IW'(1);
      end
      if (shift_b) begin
        b <= {b[DW-5:0], nib};
        if (b_cnt != ND_I) b_cnt <= b_cnt + IW'(1);
      end
      if (latch_op) op_sub <= (rx_data == 8'h2D);
      if (do_calc) {ovf, result} <= calc_ext;
    end
  end

  // Transmit request register: one-cycle pulse plus the guard cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_gap   <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= issue;
      tx_gap   <= tx_start;
      if (issue) tx_data <= issue_byte;
    end
  end

endmodule
